led_matrix_scanner: RTL and testbench



---
 rtl/led_matrix_scanner_if.sv | 13 +
 rtl/led_matrix_scanner.sv | 73 +++++++
 tb/tb_led_matrix_scanner.sv | 125 ++++++++++++
 3 files changed

// File: rtl/led_matrix_scanner_if.sv
// led_matrix_scanner_if: pixel arrays in, row/column LED drive out, between game logic and the scanner
interface led_matrix_scanner_if;
  logic EN;
  logic [15:0][15:0] RedPixels;
  logic [15:0][15:0] GrnPixels;
  logic [15:0] RowSink;
  logic [15:0] RedDriver;
  logic [15:0] GrnDriver;
  logic FrameStart;
  logic [3:0] CurRow;
  modport master (output EN, RedPixels, GrnPixels, input RowSink, RedDriver, GrnDriver, FrameStart, CurRow);
  modport slave (input EN, RedPixels, GrnPixels, output RowSink, RedDriver, GrnDriver, FrameStart, CurRow);
endinterface

// File: rtl/led_matrix_scanner.sv
// led_matrix_scanner: row-scans a per-frame snapshot of the red/green pixel arrays onto the LED matrix
module led_matrix_scanner #(
  parameter int DWELL_CYCLES = 1000,
  parameter int BLANK_CYCLES = 50
) (
  input logic CLK,
  input logic RST,
  led_matrix_scanner_if.slave bus
);
  localparam int DW = DWELL_CYCLES > 1 ? $clog2(DWELL_CYCLES) : 1;
  localparam int BW = BLANK_CYCLES > 1 ? $clog2(BLANK_CYCLES) : 1;
  localparam logic [DW-1:0] DWELL_LAST = DW'(DWELL_CYCLES - 1);
  localparam logic [BW-1:0] BLANK_LAST = BW'(BLANK_CYCLES > 0 ? BLANK_CYCLES - 1 : 0);
  typedef enum logic [1:0] {IDLE, LOAD, BLANK, DRIVE} state_t;
  state_t state, state_n;
  logic [DW-1:0] dwell_cnt;
  logic [BW-1:0] blank_cnt;
  logic [15:0][15:0] snap_red, snap_grn;
  logic [3:0] row_n;
  logic [15:0] sink_n, red_n, grn_n;
  logic dwell_done, blank_done;
  assign dwell_done = dwell_cnt == DWELL_LAST;
  assign blank_done = blank_cnt == BLANK_LAST;
  // state, counters, snapshot and registered outputs all move on the same edge
  always_ff @(posedge CLK) begin
    if (RST) begin
      state <= IDLE;
      dwell_cnt <= '0;
      blank_cnt <= '0;
      snap_red <= '0;
      snap_grn <= '0;
      bus.RowSink <= 16'hFFFF;
      bus.RedDriver <= '0;
      bus.GrnDriver <= '0;
      bus.FrameStart <= 1'b0;
      bus.CurRow <= '0;
    end else begin
      state <= state_n;
      dwell_cnt <= (state != DRIVE || dwell_done) ? '0 : dwell_cnt + 1'b1;
      blank_cnt <= (state != BLANK || blank_done) ? '0 : blank_cnt + 1'b1;
      if (state_n == LOAD) begin
        snap_red <= bus.RedPixels;
        snap_grn <= bus.GrnPixels;
      end
      bus.RowSink <= sink_n;
      bus.RedDriver <= red_n;
      bus.GrnDriver <= grn_n;
      bus.FrameStart <= state_n == LOAD;
      bus.CurRow <= row_n;
    end
  end
  // next state and next row; EN only matters in IDLE and at the end of row 15
  always_comb begin
    state_n = state;
    row_n = bus.CurRow;
    case (state)
      IDLE: state_n = bus.EN ? LOAD : IDLE;
      LOAD: state_n = BLANK_CYCLES == 0 ? DRIVE : BLANK;
      BLANK: state_n = blank_done ? DRIVE : BLANK;
      DRIVE: if (dwell_done) begin
        state_n = bus.CurRow == 4'd15 ? (bus.EN ? LOAD : IDLE) : (BLANK_CYCLES == 0 ? DRIVE : BLANK);
        row_n = bus.CurRow == 4'd15 ? bus.CurRow : bus.CurRow + 4'd1;
      end
    endcase
    if (state_n == LOAD) row_n = '0;
  end
  // drive pattern for the state being entered; dark everywhere except DRIVE
  always_comb begin
    sink_n = state_n == DRIVE ? ~(16'h1 << row_n) : 16'hFFFF;
    red_n = state_n == DRIVE ? snap_red[row_n] : '0;
    grn_n = state_n == DRIVE ? snap_grn[row_n] : '0;
  end
endmodule

// File: tb/tb_led_matrix_scanner.sv
// tb_led_matrix_scanner: directed checks of scan timing, snapshot isolation, EN drop and reset
module tb_led_matrix_scanner;
  logic CLK = 1'b0;
  logic RST = 1'b1;
  int checks = 0;
  int errors = 0;
  led_matrix_scanner_if ia ();
  led_matrix_scanner_if ib ();
  led_matrix_scanner #(.DWELL_CYCLES(4), .BLANK_CYCLES(1)) u_a (.CLK(CLK), .RST(RST), .bus(ia));
  led_matrix_scanner #(.DWELL_CYCLES(1), .BLANK_CYCLES(0)) u_b (.CLK(CLK), .RST(RST), .bus(ib));
  always #5 CLK = ~CLK;
  task automatic tick();
    @(posedge CLK);
    #1;
  endtask
  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask
  task automatic dark_a(input string tag, input logic fs);
    chk({tag, " sink"}, ia.RowSink, 16'hFFFF);
    chk({tag, " red"}, ia.RedDriver, 16'h0000);
    chk({tag, " grn"}, ia.GrnDriver, 16'h0000);
    chk({tag, " fs"}, 16'(ia.FrameStart), 16'(fs));
  endtask
  task automatic row_a(input int r, input logic [15:0] red, input logic [15:0] grn);
    tick();
    dark_a($sformatf("a_blank%0d", r), 1'b0);
    chk($sformatf("a_blank%0d row", r), 16'(ia.CurRow), 16'(r));
    repeat (4) begin
      tick();
      chk($sformatf("a_drive%0d sink", r), ia.RowSink, ~(16'h1 << r));
      chk($sformatf("a_drive%0d red", r), ia.RedDriver, red);
      chk($sformatf("a_drive%0d grn", r), ia.GrnDriver, grn);
      chk($sformatf("a_drive%0d fs", r), 16'(ia.FrameStart), 16'h0);
      chk($sformatf("a_drive%0d row", r), 16'(ia.CurRow), 16'(r));
    end
  endtask
  task automatic drive_b(input int r);
    tick();
    chk($sformatf("b_drive%0d sink", r), ib.RowSink, ~(16'h1 << r));
    chk($sformatf("b_drive%0d red", r), ib.RedDriver, 16'(16'h8000 >> r));
    chk($sformatf("b_drive%0d grn", r), ib.GrnDriver, 16'(16'h1 << r));
    chk($sformatf("b_drive%0d fs", r), 16'(ib.FrameStart), 16'h0);
    chk($sformatf("b_drive%0d row", r), 16'(ib.CurRow), 16'(r));
  endtask
  initial begin
    ia.EN = 1'b0;
    ia.RedPixels = '0;
    ia.GrnPixels = '0;
    ib.EN = 1'b0;
    ib.RedPixels = '0;
    ib.GrnPixels = '0;
    tick();
    tick();
    dark_a("reset_a", 1'b0);
    chk("reset_a row", 16'(ia.CurRow), 16'h0);
    RST = 1'b0;
    repeat (20) begin
      tick();
      dark_a("idle_a", 1'b0);
      chk("idle_a row", 16'(ia.CurRow), 16'h0);
    end
    for (int r = 0; r < 16; r++) ia.GrnPixels[r] = 16'(16'h1 << r);
    ia.EN = 1'b1;
    tick();
    dark_a("load1", 1'b1);
    chk("load1 row", 16'(ia.CurRow), 16'h0);
    for (int r = 0; r < 16; r++) begin
      row_a(r, 16'h0000, 16'(16'h1 << r));
      if (r == 7) ia.GrnPixels = '1;
    end
    tick();
    dark_a("load2", 1'b1);
    chk("load2 row", 16'(ia.CurRow), 16'h0);
    ia.RedPixels[3] = 16'h00F0;
    ia.GrnPixels[3] = 16'h0FF0;
    for (int r = 0; r < 16; r++) row_a(r, 16'h0000, 16'hFFFF);
    tick();
    dark_a("load3", 1'b1);
    for (int r = 0; r < 16; r++) begin
      row_a(r, r == 3 ? 16'h00F0 : 16'h0000, r == 3 ? 16'h0FF0 : 16'hFFFF);
      if (r == 5) ia.EN = 1'b0;
    end
    repeat (5) begin
      tick();
      dark_a("idle_after_drop", 1'b0);
    end
    ia.EN = 1'b1;
    tick();
    dark_a("reload", 1'b1);
    chk("reload row", 16'(ia.CurRow), 16'h0);
    for (int r = 0; r < 16; r++) begin
      ib.GrnPixels[r] = 16'(16'h1 << r);
      ib.RedPixels[r] = 16'(16'h8000 >> r);
    end
    ib.EN = 1'b1;
    tick();
    chk("b_load1 fs", 16'(ib.FrameStart), 16'h1);
    chk("b_load1 sink", ib.RowSink, 16'hFFFF);
    for (int r = 0; r < 16; r++) drive_b(r);
    tick();
    chk("b_load2 fs", 16'(ib.FrameStart), 16'h1);
    chk("b_load2 sink", ib.RowSink, 16'hFFFF);
    chk("b_load2 row", 16'(ib.CurRow), 16'h0);
    for (int r = 0; r <= 10; r++) drive_b(r);
    RST = 1'b1;
    tick();
    chk("b_rst sink", ib.RowSink, 16'hFFFF);
    chk("b_rst red", ib.RedDriver, 16'h0000);
    chk("b_rst grn", ib.GrnDriver, 16'h0000);
    chk("b_rst fs", 16'(ib.FrameStart), 16'h0);
    chk("b_rst row", 16'(ib.CurRow), 16'h0);
    RST = 1'b0;
    tick();
    chk("b_restart fs", 16'(ib.FrameStart), 16'h1);
    chk("b_restart sink", ib.RowSink, 16'hFFFF);
    drive_b(0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
